// File: rtl/decomp_pkg.sv
// Shared constants, state encoding and sec-level helper for the decomposer
// sequencer (decompose_ctrl and decomp_prefetch_fifo).
package decomp_pkg;

    localparam int COEFF_W = 24;
    localparam int LANES   = 4;
    localparam int N_COEFF = 256;
    localparam int ADDR_W  = 6;
    localparam int WORD_W  = LANES * COEFF_W;
    localparam int N_WORDS = N_COEFF / LANES;
    localparam int CNT_W   = ADDR_W + 1;

    localparam logic [22:0] Q = 23'd8380417;

    localparam logic [2:0] SEC_LVL_2 = 3'b010;
    localparam logic [2:0] SEC_LVL_3 = 3'b011;
    localparam logic [2:0] SEC_LVL_5 = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } ctrl_state_e;

    function automatic logic sec_lvl_legal(input logic [2:0] lvl);
        return (lvl == SEC_LVL_2) || (lvl == SEC_LVL_3) || (lvl == SEC_LVL_5);
    endfunction

endpackage

// File: rtl/decomp_prefetch_fifo.sv
// Two-entry prefetch buffer between the 1-cycle coefficient RAM and the
// decomposer input; tracks occupancy plus the read in flight.
module decomp_prefetch_fifo
    import decomp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_i,
    input  logic [WORD_W-1:0] rd_data_i,
    input  logic              pop_i,
    output logic              can_issue_o,
    output logic              valid_o,
    output logic [WORD_W-1:0] head_o
);
    logic [WORD_W-1:0] mem_q [2];
    logic [1:0]        count_q, count_d;
    logic [1:0]        avail;
    logic              inflight_q;
    logic              wptr_q, rptr_q;

    // Words usable this cycle: stored entries plus the one arriving from RAM.
    assign avail       = count_q + {1'b0, inflight_q};
    assign count_d     = avail - {1'b0, pop_i};
    assign can_issue_o = (count_d < 2'd2);
    assign valid_o     = (avail != 2'd0);

    // An empty buffer forwards the arriving word directly so a full-rate stream sees no bubble.
    always_comb begin
        head_o = '0;
        if (count_q != 2'd0) begin
            head_o = mem_q[rptr_q];
        end else if (inflight_q) begin
            head_o = rd_data_i;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (!rst) begin
                mem_q[gi] <= '0;
            end else if (inflight_q && (wptr_q == 1'(gi))) begin
                mem_q[gi] <= rd_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q    <= '0;
            inflight_q <= 1'b0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= issue_i;
            wptr_q     <= wptr_q ^ inflight_q;
            rptr_q     <= rptr_q ^ pop_i;
        end
    end

endmodule

// File: rtl/decompose_ctrl.sv
// Sequencer streaming one 256-coefficient polynomial through coeff_decomposer into r1/r0 RAMs.
// Defining DECOMP_STALL_CNT_EN adds the saturating stall counter on stall_cnt.
module decompose_ctrl
    import decomp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        sec_lvl,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic [2:0]        dec_sec_lvl,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [WORD_W-1:0] dec_di,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [WORD_W-1:0] dec_doa,
    input  logic [WORD_W-1:0] dec_dob,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_r1,
    output logic [WORD_W-1:0] wr_r0,
    output logic [15:0]       stall_cnt
);
    ctrl_state_e      state_q, state_d;
    logic [2:0]       lvl_q, lvl_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             running, start_ok, in_hs, out_hs, can_issue, buf_valid;
    logic [WORD_W-1:0] buf_head;

    assign running     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign start_ok    = (state_q == ST_IDLE) && start && sec_lvl_legal(sec_lvl);
    assign dec_valid_o = buf_valid && (in_cnt_q < CNT_W'(N_WORDS));
    assign dec_di      = buf_head;
    assign in_hs       = dec_valid_o && dec_ready_i;
    assign dec_ready_o = running && (out_cnt_q < CNT_W'(N_WORDS));
    assign out_hs      = dec_valid_i && dec_ready_o;
    assign rd_en       = (state_q == ST_RUN) && (rd_cnt_q < CNT_W'(N_WORDS)) && can_issue;
    assign rd_addr     = rd_cnt_q[ADDR_W-1:0];

    assign busy        = running;
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;
    assign dec_sec_lvl = lvl_q;
    assign wr_en       = out_hs;
    assign wr_addr     = out_cnt_q[ADDR_W-1:0];
    assign wr_r1       = out_hs ? dec_doa : '0;
    assign wr_r0       = out_hs ? dec_dob : '0;

    decomp_prefetch_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .issue_i     (rd_en),
        .rd_data_i   (rd_data),
        .pop_i       (in_hs),
        .can_issue_o (can_issue),
        .valid_o     (buf_valid),
        .head_o      (buf_head)
    );

    always_comb begin
        state_d   = state_q;
        lvl_d     = lvl_q;
        err_d     = err_q;
        rd_cnt_d  = rd_cnt_q + CNT_W'(rd_en);
        in_cnt_d  = in_cnt_q + CNT_W'(in_hs);
        out_cnt_d = out_cnt_q + CNT_W'(out_hs);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (sec_lvl_legal(sec_lvl)) begin
                        state_d   = ST_RUN;
                        lvl_d     = sec_lvl;
                        err_d     = 1'b0;
                        rd_cnt_d  = '0;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (rd_en && (rd_cnt_q == CNT_W'(N_WORDS - 1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_cnt_d == CNT_W'(N_WORDS)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            lvl_q     <= '0;
            err_q     <= 1'b0;
            rd_cnt_q  <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lvl_q     <= lvl_d;
            err_q     <= err_d;
            rd_cnt_q  <= rd_cnt_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

`ifdef DECOMP_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
    logic        stall_event;

    // Pipeline fill before the first read is issued is not a starvation stall.
    assign stall_event = (running && dec_valid_o && !dec_ready_i) ||
                         ((state_q == ST_RUN) && !buf_valid && (rd_cnt_q != '0));

    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = '0;
        end else if (stall_event && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_decompose_ctrl.sv
// Directed bench for decompose_ctrl: RAM model, variable-latency decomposer model
// and a write scoreboard; set DECOMP_STALL_CNT_EN to check the stall counter.
module tb_decompose_ctrl;
    import decomp_pkg::*;

    localparam logic [WORD_W-1:0] R1_MASK = {4{24'h5AC3A5}};

    logic              clk = 1'b0;
    logic              rst, start, busy, done, err, rd_en;
    logic [2:0]        sec_lvl, dec_sec_lvl;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [WORD_W-1:0] rd_data, dec_di, dec_doa, dec_dob, wr_r1, wr_r0;
    logic              dec_valid_o, dec_ready_i, dec_valid_i, dec_ready_o, wr_en;
    logic [15:0]       stall_cnt;

    always #5 clk = ~clk;

    decompose_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .sec_lvl(sec_lvl), .busy(busy), .done(done),
        .err(err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .dec_sec_lvl(dec_sec_lvl), .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .dec_di(dec_di), .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .dec_doa(dec_doa), .dec_dob(dec_dob), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_r1(wr_r1), .wr_r0(wr_r0), .stall_cnt(stall_cnt)
    );

    typedef struct {
        int                addr;
        logic [WORD_W-1:0] r1;
        logic [WORD_W-1:0] r0;
    } exp_t;

    exp_t              exp_q[$];
    logic [WORD_W-1:0] dq_data[$];
    int                dq_time[$];
    int                dq_idx[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [23:0] seed = '0;
    bit          bp_rand = 1'b0;
    int          low_from = -1;
    int          low_len = 0;
    int          hold_beat = -1;
    int          hold_left = 0;
    int          in_idx, rd_expect, done_cnt, done_tick;
    bit          zero_check = 1'b0;
    bit          prev_stall = 1'b0;
    logic [WORD_W-1:0] prev_di;

    function automatic logic [WORD_W-1:0] ram_word(input int k);
        return {4{24'(k) ^ seed}};
    endfunction

    task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Decomposer model: returns in order, ready for output 3 cycles after input acceptance.
    task automatic drive_inputs();
        if (bp_rand) dec_ready_i = 1'($urandom_range(0, 1));
        else dec_ready_i = !((low_from >= 0) && (cyc >= low_from) && (cyc < low_from + low_len));
        dec_valid_i = 1'b0;
        dec_doa = {$urandom, $urandom, $urandom};
        dec_dob = {$urandom, $urandom, $urandom};
        if ((dq_time.size() > 0) && (dq_time[0] <= cyc)) begin
            if ((dq_idx[0] == hold_beat) && (hold_left > 0)) begin
                hold_left--;
            end else begin
                dec_valid_i = 1'b1;
                dec_doa = dq_data[0] ^ R1_MASK;
                dec_dob = ~dq_data[0];
            end
        end
    endtask

    task automatic tick();
        logic              s_rd_en, in_hs, out_hs;
        logic [ADDR_W-1:0] s_rd_addr;
        exp_t              e;
        @(negedge clk);
        in_hs     = dec_valid_o && dec_ready_i;
        out_hs    = dec_valid_i && dec_ready_o;
        s_rd_en   = rd_en;
        s_rd_addr = rd_addr;
        if (zero_check) begin
            chk("rst_busy", WORD_W'(busy), '0);
            chk("rst_done", WORD_W'(done), '0);
            chk("rst_err", WORD_W'(err), '0);
            chk("rst_rd_en", WORD_W'(rd_en), '0);
            chk("rst_rd_addr", WORD_W'(rd_addr), '0);
            chk("rst_dec_valid_o", WORD_W'(dec_valid_o), '0);
            chk("rst_dec_ready_o", WORD_W'(dec_ready_o), '0);
            chk("rst_dec_di", dec_di, '0);
            chk("rst_dec_sec_lvl", WORD_W'(dec_sec_lvl), '0);
            chk("rst_wr_en", WORD_W'(wr_en), '0);
            chk("rst_wr_addr", WORD_W'(wr_addr), '0);
            chk("rst_wr_r1", wr_r1, '0);
            chk("rst_wr_r0", wr_r0, '0);
            chk("rst_stall_cnt", WORD_W'(stall_cnt), '0);
        end else begin
            chk("wr_en_vs_handshake", WORD_W'(wr_en), WORD_W'(out_hs));
            if (prev_stall) begin
                chk("di_valid_held", WORD_W'(dec_valid_o), WORD_W'(1));
                chk("di_stable", dec_di, prev_di);
            end
            if (s_rd_en) begin
                chk("rd_addr", WORD_W'(s_rd_addr), WORD_W'(rd_expect));
                rd_expect++;
            end
            if (in_hs) begin
                chk("dec_di", dec_di, ram_word(in_idx));
                e.addr = in_idx;
                e.r1   = ram_word(in_idx) ^ R1_MASK;
                e.r0   = ~ram_word(in_idx);
                exp_q.push_back(e);
                dq_data.push_back(dec_di);
                dq_time.push_back(cyc + 3);
                dq_idx.push_back(in_idx);
                in_idx++;
            end
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", WORD_W'(wr_en), '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", WORD_W'(wr_addr), WORD_W'(e.addr));
                    chk("wr_r1", wr_r1, e.r1);
                    chk("wr_r0", wr_r0, e.r0);
                end
            end
            if (out_hs && (dq_time.size() > 0)) begin
                void'(dq_data.pop_front());
                void'(dq_time.pop_front());
                void'(dq_idx.pop_front());
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", WORD_W'(busy), '0);
            end
        end
        prev_stall = dec_valid_o && !dec_ready_i;
        prev_di    = dec_di;
        @(posedge clk);
        #1;
        cyc++;
        if (s_rd_en) rd_data = ram_word(int'(s_rd_addr));
        drive_inputs();
    endtask

    task automatic init_run();
        in_idx = 0; rd_expect = 0; done_cnt = 0; prev_stall = 1'b0;
        exp_q.delete(); dq_data.delete(); dq_time.delete(); dq_idx.delete();
    endtask

    task automatic run_poly(input logic [2:0] lvl, input int mid_start_at, input int max_lat);
        int n;
        init_run();
        start = 1'b1; sec_lvl = lvl;
        tick();
        start = 1'b0;
        chk("busy_after_start", WORD_W'(busy), WORD_W'(1));
        chk("err_after_start", WORD_W'(err), '0);
        chk("sec_lvl_latched", WORD_W'(dec_sec_lvl), WORD_W'(lvl));
        n = 1;
        while ((done_cnt == 0) && (n < 2000)) begin
            if (n == mid_start_at) begin
                start = 1'b1; sec_lvl = SEC_LVL_5;
            end
            tick();
            start = 1'b0;
            n++;
        end
        done_tick = n - 1;
        chk("done_seen", WORD_W'(done_cnt != 0), WORD_W'(1));
        chk("latency_ok", WORD_W'(done_tick <= max_lat), WORD_W'(1));
        repeat (3) tick();
        chk("done_once", WORD_W'(done_cnt), WORD_W'(1));
        chk("reads_issued", WORD_W'(rd_expect), WORD_W'(N_WORDS));
        chk("beats_in", WORD_W'(in_idx), WORD_W'(N_WORDS));
        chk("writes_left", WORD_W'(exp_q.size()), '0);
        chk("idle_busy", WORD_W'(busy), '0);
        chk("sec_lvl_held", WORD_W'(dec_sec_lvl), WORD_W'(lvl));
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; sec_lvl = '0; rd_data = '0;
        dec_ready_i = 1'b1; dec_valid_i = 1'b0; dec_doa = '0; dec_dob = '0;
        init_run();
        repeat (2) @(posedge clk);
        #1;
        zero_check = 1'b1;
        tick();
        zero_check = 1'b0;
        rst = 1'b1;
        repeat (2) tick();

        // Ideal run, word k = {4{k}}
        seed = 24'h000000;
        run_poly(SEC_LVL_2, -1, 70);
        chk("stall_ideal", WORD_W'(stall_cnt), '0);

        // Random input backpressure plus an ignored start while busy
        seed = 24'h13579B;
        bp_rand = 1'b1;
        run_poly(SEC_LVL_3, 20, 2000);
        bp_rand = 1'b0;

        // Decomposer withholds beat 10 for 5 cycles
        seed = 24'hC0FFEE;
        hold_beat = 10; hold_left = 5;
        run_poly(SEC_LVL_5, -1, 2000);
        chk("hold_applied", WORD_W'(hold_left), '0);
        hold_beat = -1;

        // Illegal level, then a legal start clears err
        init_run();
        start = 1'b1; sec_lvl = 3'b000;
        tick();
        start = 1'b0;
        chk("illegal_err", WORD_W'(err), WORD_W'(1));
        chk("illegal_busy", WORD_W'(busy), '0);
        repeat (4) tick();
        chk("illegal_no_rd", WORD_W'(rd_expect), '0);
        chk("illegal_err_sticky", WORD_W'(err), WORD_W'(1));
        seed = 24'h0A0B0C;
        run_poly(SEC_LVL_5, -1, 2000);

        // Reset in the middle of a run, then a clean run
        init_run();
        seed = 24'h777777;
        start = 1'b1; sec_lvl = SEC_LVL_3;
        tick();
        start = 1'b0;
        n = 0;
        while ((in_idx < 30) && (n < 500)) begin
            tick();
            n++;
        end
        chk("reached_word30", WORD_W'(in_idx >= 30), WORD_W'(1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        init_run();
        drive_inputs();
        zero_check = 1'b1;
        tick();
        zero_check = 1'b0;
        repeat (6) tick();
        chk("post_rst_no_rd", WORD_W'(rd_expect), '0);
        chk("post_rst_no_done", WORD_W'(done_cnt), '0);
        run_poly(SEC_LVL_2, -1, 70);

        // Exactly 7 cycles of input backpressure during an otherwise ideal run
        seed = 24'h2468AC;
        low_from = cyc + 20; low_len = 7;
        run_poly(SEC_LVL_2, -1, 77);
        low_from = -1;
`ifdef DECOMP_STALL_CNT_EN
        chk("stall_cnt", WORD_W'(stall_cnt), WORD_W'(7));
`else
        chk("stall_cnt", WORD_W'(stall_cnt), '0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decompose_ctrl.md
Name: decompose_ctrl

Overview:
- Sequencer that streams one 256-coefficient polynomial from coefficient RAM through coeff_decomposer, 4 coefficients per beat.
- Writes the high part (r1) and low part (r0) into two result RAMs.
- Sits between the polynomial memory bank and the decomposer. Used by sign/verify for w1/w0 extraction.
- Owns start/done control, security-level latching and valid/ready flow on both sides of the decomposer.

Parameters:
- COEFF_W, 24, coefficient width in bits
- LANES, 4, coefficients per memory word / decomposer beat
- N_COEFF, 256, coefficients per polynomial
- ADDR_W, 6, word address width (log2(N_COEFF/LANES))

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse; begin one polynomial
- sec_lvl  in  3  security level: 3'b010, 3'b011 or 3'b101 legal
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last result write
- err  out  1  sticky; illegal sec_lvl seen at start; cleared by next legal start
- rd_en  out  1  coefficient RAM read enable
- rd_addr  out  ADDR_W  coefficient RAM word address
- rd_data  in  LANES*COEFF_W  read data, valid exactly 1 cycle after rd_en
- dec_sec_lvl  out  3  latched level driven to decomposer
- dec_valid_o  out  1  to decomposer valid_i
- dec_ready_i  in  1  from decomposer ready_i
- dec_di  out  LANES*COEFF_W  to decomposer di
- dec_valid_i  in  1  from decomposer valid_o
- dec_ready_o  out  1  to decomposer ready_o
- dec_doa  in  LANES*COEFF_W  r1 lanes
- dec_dob  in  LANES*COEFF_W  r0 lanes
- wr_en  out  1  result RAM write enable, shared by r1 and r0 RAMs
- wr_addr  out  ADDR_W  result word address
- wr_r1  out  LANES*COEFF_W  r1 write data
- wr_r0  out  LANES*COEFF_W  r0 write data
- stall_cnt  out  16  see Optional Feature

Behaviour:
Reset and clock
- Single clock clk. rst is synchronous and active-low: sampled on the clk edge while rst==0.
- All outputs reset to 0. FSM goes to IDLE; all counters and the prefetch buffer are cleared.
- Reset mid-operation aborts immediately. No further rd_en or wr_en is asserted and no done pulse is produced.

FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE
- IDLE:
  - start with a legal sec_lvl: latch it into dec_sec_lvl, clear err, go to RUN.
  - start with an illegal sec_lvl: set err, stay in IDLE, busy stays 0.
- RUN:
  - Issue reads at rd_addr 0..63 in order.
  - A read is issued only if the prefetch buffer will have a free slot when the data returns (occupancy + reads in flight < 2). This gives full throughput with a 1-cycle RAM.
  - After address 63 is issued, go to DRAIN.
- DRAIN: wait until all 64 output beats are written.
- DONE: done=1 for exactly one cycle, busy drops in the same cycle, then IDLE.
- start while busy is ignored.

Input side
- dec_valid_o = buffer non-empty; dec_di = buffer head.
- A beat transfers on dec_valid_o && dec_ready_i.
- dec_di must stay stable while dec_valid_o is high and dec_ready_i is low.

Output side
- dec_ready_o is 1 in RUN and DRAIN, 0 otherwise.
- A beat is accepted on dec_valid_i && dec_ready_o. In the same cycle: wr_en=1, wr_r1=dec_doa, wr_r0=dec_dob, wr_addr=out counter. The counter then increments.
- No extra cycle: write latency from output handshake is 0 (combinational to registered-out is not required).

Counters and limits
- Read counter, input counter and output counter are 7 bits so 64 is representable; no wrap within an operation.
- The output counter reaching 64 is the only DRAIN exit.
- Output beats beyond 64 are not accepted (dec_ready_o=0 once the counter is 64).

Ordering and decomposer latency
- The decomposer's latency is arbitrary; the controller relies on in-order returns only.
- Simultaneous input and output handshakes in the same cycle are both honoured.

Optional Feature:
- Macro: DECOMP_STALL_CNT_EN.
- With it:
  - stall_cnt counts cycles where busy && dec_valid_o && !dec_ready_i, plus cycles where the buffer is empty in RUN.
  - Saturates at 16'hFFFF; clears on accepted start; holds its value after done.
- Without it: stall_cnt is tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package decomp_pkg:
  - sec-level constants SEC_LVL_2/3/5
  - COEFF_W, LANES, N_COEFF, ADDR_W
  - Q = 23'd8380417
  - ctrl state enum
- One sub-module, decomp_prefetch_fifo: 2-entry FIFO with 1-cycle-latency fill tracking; owns occupancy and in-flight accounting.

Test Plan:
- Basic run: reset, then start with sec_lvl=3'b010 and RAM word k = {4{24'(k)}}; decomposer model with fixed latency 3 and always ready -> 64 writes in address order 0..63, done exactly once, total start-to-done ≤ 64+6 cycles.
- Input backpressure: dec_ready_i random at 50% -> dec_di stable under stall, all 64 words delivered in order, none duplicated.
- Output backpressure: decomposer model holds valid_o for 5 cycles on beat 10 -> wr_en never asserted without dec_valid_i, wr_addr continues at 10.
- Illegal level: start with sec_lvl=3'b000 -> err=1, busy=0, no rd_en. A following start with 3'b101 -> err clears and a normal run completes.
- Reset mid-run: rst low at word 30 -> next cycle all outputs 0, FSM IDLE, no done. A fresh start runs 0..63 cleanly.
- DECOMP_STALL_CNT_EN: ready_i low for exactly 7 cycles during an otherwise ideal run -> stall_cnt = 7; with the macro undefined, stall_cnt = 0.
